dac_quantizer: RTL and testbench

DAC_QUANTIZER -- requirements
Module: dac_quantizer

---
 rtl/dac_quantizer_if.sv | 29 ++
 rtl/dac_quantizer.sv | 235 +++++++++++++++++++++++
 tb/tb_dac_quantizer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_quantizer_if.sv
// -----------------------------------------------------------------------------
// dac_quantizer_if
// Sample-input handshake bundle for dac_quantizer.
//
//   s_data   signed Q(INT).(FRAC) sample, DATA_WIDTH bits (master -> slave)
//   s_valid  s_data is valid                           (master -> slave)
//   s_ready  slave can take s_data this cycle          (slave  -> master)
//
// A sample transfers on a rising edge where s_valid and s_ready are both 1.
// -----------------------------------------------------------------------------
interface dac_quantizer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/dac_quantizer.sv
// -----------------------------------------------------------------------------
// dac_quantizer
// Converts a signed fixed-point sample stream into a signed DAC code:
// round-half-up, arithmetic shift, saturate, then an optional slew limiter.
//
// Ports
//   adc_clk    single clock, rising edge
//   adc_rst    synchronous, active-high reset
//   s_if       sample input handshake (s_data / s_valid / s_ready)
//   dac_data   signed DAC code, holds between updates
//   dac_valid  one-cycle pulse on every dac_data update
//   sat_flag   sticky: a sample was clamped to the DAC range
//   sat_clr    clears sat_flag (a clamp on the same edge wins)
//
// Pipeline (unstalled): accept at edge k -> stage 1 (rounded value) at k,
// stage 2 (clamped target) at k+1, dac_data at k+2.
//
// Build option
//   DAC_QUANT_SLEW_LIMIT_EN  defined: dac_data moves at most MAX_STEP codes
//                            per cycle via an IDLE/SLEW FSM, with back-pressure.
//                            undefined: dac_data takes every target directly
//                            and s_ready is 1 outside reset.
// -----------------------------------------------------------------------------
module dac_quantizer #(
    parameter int DATA_WIDTH = 32,
    parameter int INT_WIDTH  = 16,
    parameter int DAC_WIDTH  = 14,
    parameter int MAX_STEP   = 64
) (
    input  logic                        adc_clk,
    input  logic                        adc_rst,
    dac_quantizer_if.slave              s_if,
    output logic signed [DAC_WIDTH-1:0] dac_data,
    output logic                        dac_valid,
    output logic                        sat_flag,
    input  logic                        sat_clr
);

    localparam int FRAC = DATA_WIDTH - INT_WIDTH;
    // Bits dropped between the input fraction and the DAC code.
    localparam int SH   = FRAC - (DAC_WIDTH - 1);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int SW   = DATA_WIDTH + 1;

    localparam logic signed [SW-1:0] ROUND_HALF = SW'(1) <<< (SH - 1);
    localparam logic signed [SW-1:0] CODE_MAX   = SW'((1 << (DAC_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] CODE_MIN   = ~CODE_MAX;

    if (SH < 1 || MAX_STEP < 1) begin : g_param_check
        $error("dac_quantizer: FRAC must exceed DAC_WIDTH-1 and MAX_STEP must be >= 1");
    end

    // ---------------------------------------------------------------- stages
    logic signed [SW-1:0]        s1_q, s1_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [DAC_WIDTH-1:0] s2_q, s2_d;
    logic                        s2_valid_q, s2_valid_d;
    logic                        sat_q, sat_d;

    logic signed [DAC_WIDTH-1:0] dac_q, dac_d;
    logic                        dac_valid_q, dac_valid_d;

    logic signed [SW-1:0]        shifted;
    logic signed [DAC_WIDTH-1:0] target;
    logic                        clamp;

    logic accept;    // sample transfers this edge
    logic s2_take;   // output stage consumes the stage 2 target this edge
    logic s2_free;   // stage 2 can load this edge
    logic s1_move;   // stage 1 hands its value to stage 2 this edge
    logic stall;     // both stages full behind a slewing output

    assign accept  = s_if.s_valid && s_if.s_ready;
    assign s2_free = !s2_valid_q || s2_take;
    assign s1_move = s1_valid_q && s2_free;

    // Ready drops combinationally with reset so it is low throughout reset
    // and high on the very first cycle after reset is released.
    assign s_if.s_ready = !adc_rst && !stall;

    assign shifted = s1_q >>> SH;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        target = shifted[DAC_WIDTH-1:0];
        clamp  = 1'b0;
        if (shifted > CODE_MAX) begin
            target = CODE_MAX[DAC_WIDTH-1:0];
            clamp  = 1'b1;
        end else if (shifted < CODE_MIN) begin
            target = CODE_MIN[DAC_WIDTH-1:0];
            clamp  = 1'b1;
        end
    end

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_d       = $signed({s_if.s_data[DATA_WIDTH-1], s_if.s_data}) + ROUND_HALF;
            s1_valid_d = 1'b1;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s1_move) begin
            s2_d       = target;
            s2_valid_d = 1'b1;
        end else if (s2_take) begin
            s2_valid_d = 1'b0;
        end

        // A clamp registering this edge beats a simultaneous clear.
        sat_d = sat_q;
        if (s1_move && clamp) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end
    end

    // ---------------------------------------------------------- output stage
`ifdef DAC_QUANT_SLEW_LIMIT_EN
    localparam int DW1 = DAC_WIDTH + 1;
    localparam logic signed [DW1-1:0] STEP = DW1'(MAX_STEP);

    typedef enum logic {
        IDLE,
        SLEW
    } state_e;

    state_e                      state_q, state_d;
    logic signed [DAC_WIDTH-1:0] goal_q, goal_d;
    logic signed [DAC_WIDTH-1:0] aim;
    logic signed [DW1-1:0]       dist;
    logic                        near;
    logic signed [DAC_WIDTH-1:0] step_dac;

    // Distance is measured to the new target in IDLE and to the latched goal
    // in SLEW; one extra bit keeps the full-scale difference representable.
    assign aim      = (state_q == SLEW) ? goal_q : s2_q;
    assign dist     = DW1'(aim) - DW1'(dac_q);
    assign near     = (dist <= STEP) && (dist >= -STEP);
    assign step_dac = DAC_WIDTH'(DW1'(dac_q) + (dist[DW1-1] ? -STEP : STEP));
    assign stall    = (state_q == SLEW) && s1_valid_q && s2_valid_q;

    always_comb begin
        state_d     = state_q;
        goal_d      = goal_q;
        dac_d       = dac_q;
        dac_valid_d = 1'b0;
        s2_take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_valid_q) begin
                    s2_take     = 1'b1;
                    dac_valid_d = 1'b1;
                    if (near) begin
                        dac_d = s2_q;
                    end else begin
                        goal_d  = s2_q;
                        dac_d   = step_dac;
                        state_d = SLEW;
                    end
                end
            end
            SLEW: begin
                // Stage 2 is left untouched here, so a waiting target holds.
                dac_valid_d = 1'b1;
                if (near) begin
                    dac_d   = goal_q;
                    state_d = IDLE;
                end else begin
                    dac_d = step_dac;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    assign stall   = 1'b0;
    assign s2_take = s2_valid_q;

    always_comb begin
        dac_d       = dac_q;
        dac_valid_d = s2_valid_q;
        if (s2_valid_q) begin
            dac_d = s2_q;
        end
    end
`endif

    // ------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            sat_q       <= 1'b0;
`ifdef DAC_QUANT_SLEW_LIMIT_EN
            state_q     <= IDLE;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            dac_q       <= dac_d;
            dac_valid_q <= dac_valid_d;
            sat_q       <= sat_d;
`ifdef DAC_QUANT_SLEW_LIMIT_EN
            state_q     <= state_d;
`endif
        end
    end

    // NOTE: payload registers are not reset; they are only read while their
    // valid bit (or the SLEW state) is set, and those are reset above.
    always_ff @(posedge adc_clk) begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
`ifdef DAC_QUANT_SLEW_LIMIT_EN
        goal_q <= goal_d;
`endif
    end

    assign dac_data  = dac_q;
    assign dac_valid = dac_valid_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dac_quantizer.sv
// -----------------------------------------------------------------------------
// tb_dac_quantizer
// Directed checks of rounding, saturation, the sticky flag, reset behaviour and
// (when DAC_QUANT_SLEW_LIMIT_EN is defined) the slew limiter, followed by a
// randomized stream scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_dac_quantizer;

    localparam int DATA_WIDTH = 32;
    localparam int INT_WIDTH  = 16;
    localparam int DAC_WIDTH  = 14;
    localparam int MAX_STEP   = 64;
    localparam int SH         = (DATA_WIDTH - INT_WIDTH) - (DAC_WIDTH - 1);
    localparam int CODE_MAX   = 2 ** (DAC_WIDTH - 1) - 1;
    localparam int CODE_MIN   = -(2 ** (DAC_WIDTH - 1));

    logic                        adc_clk = 1'b0;
    logic                        adc_rst = 1'b1;
    logic                        sat_clr = 1'b0;
    logic signed [DAC_WIDTH-1:0] dac_data;
    logic                        dac_valid;
    logic                        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    int model_dac = 0;

    dac_quantizer_if #(.DATA_WIDTH(DATA_WIDTH)) s_if ();

    dac_quantizer #(
        .DATA_WIDTH(DATA_WIDTH),
        .INT_WIDTH (INT_WIDTH),
        .DAC_WIDTH (DAC_WIDTH),
        .MAX_STEP  (MAX_STEP)
    ) dut (
        .adc_clk  (adc_clk),
        .adc_rst  (adc_rst),
        .s_if     (s_if),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: round half up to the DAC LSB (floor of value/2^SH + 1/2),
    // then clamp to the signed DAC range.
    function automatic int quantize(input logic [31:0] sample);
        longint v, num, q, div;
        div = longint'(1) << SH;
        v   = longint'($signed(sample));
        num = v + div / 2;
        q   = num / div;
        if (num < 0 && (num % div) != 0) q = q - 1;
        if (q > CODE_MAX) q = CODE_MAX;
        if (q < CODE_MIN) q = CODE_MIN;
        return int'(q);
    endfunction

    // Expected dac_data updates produced by one accepted sample.
    task automatic expect_sample(input logic [31:0] sample);
        int t;
        t = quantize(sample);
`ifdef DAC_QUANT_SLEW_LIMIT_EN
        while ((t - model_dac > MAX_STEP) || (model_dac - t > MAX_STEP)) begin
            model_dac += (t > model_dac) ? MAX_STEP : -MAX_STEP;
            exp_q.push_back(model_dac);
        end
`endif
        model_dac = t;
        exp_q.push_back(t);
    endtask

    task automatic score();
        if (exp_q.size() == 0) check("rand_extra_pulse", exp_q.size(), 1);
        else check("rand_dac", dac_data, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        tick();
        s_if.s_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] smp;
        logic        took;
        int          code;

        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;

        // ---------------------------------------------------------- reset
        repeat (3) tick();
        check("rst_dac", dac_data, 0);
        check("rst_valid", dac_valid, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_ready", s_if.s_ready, 0);
        adc_rst = 1'b0;
        #1;
        check("ready_after_rst", s_if.s_ready, 1);

`ifndef DAC_QUANT_SLEW_LIMIT_EN
        // 0.5 -> 4096, latency two edges after acceptance, single pulse.
        send(32'h0000_8000);
        tick();
        check("half_k1_valid", dac_valid, 0);
        tick();
        check("half_dac", dac_data, 4096);
        check("half_valid", dac_valid, 1);
        check("half_sat", sat_flag, 0);
        tick();
        check("half_one_pulse", dac_valid, 0);
        check("half_hold", dac_data, 4096);

        // Positive and negative clamps, sticky flag.
        send(32'h0001_0000);
        tick();
        check("pos_clamp_sat", sat_flag, 1);
        tick();
        check("pos_clamp_dac", dac_data, CODE_MAX);
        send(32'h800A_0000);
        tick();
        tick();
        check("neg_clamp_dac", dac_data, CODE_MIN);
        check("neg_clamp_sat", sat_flag, 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared", sat_flag, 0);

        // Clear on the clamp edge: set wins.
        send(32'h0001_0000);
        sat_clr = 1'b1;
        tick();
        check("sat_set_wins", sat_flag, 1);
        sat_clr = 1'b0;
        tick();
        check("clamp2_dac", dac_data, CODE_MAX);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared2", sat_flag, 0);

        // Rounding boundaries, streamed back to back (one per cycle).
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'h0000_0004;
        tick();
        s_if.s_data  = 32'h0000_0003;
        tick();
        s_if.s_data  = 32'hFFFF_0000;
        tick();
        check("rnd_up_dac", dac_data, 1);
        check("rnd_up_valid", dac_valid, 1);
        s_if.s_valid = 1'b0;
        tick();
        check("rnd_down_dac", dac_data, 0);
        check("rnd_down_valid", dac_valid, 1);
        tick();
        check("neg_full_dac", dac_data, CODE_MIN);
        check("neg_full_valid", dac_valid, 1);
        check("neg_full_nosat", sat_flag, 0);
        tick();
        check("stream_end_valid", dac_valid, 0);

        // Reset with a sample in flight: it must be discarded.
        send(32'h0000_8000);
        tick();
        adc_rst = 1'b1;
        tick();
        check("inflight_rst_dac", dac_data, 0);
        check("inflight_rst_valid", dac_valid, 0);
        adc_rst = 1'b0;
        tick();
        tick();
        check("inflight_discarded", dac_valid, 0);
        send(32'h0000_8000);
        tick();
        tick();
        check("post_rst_dac", dac_data, 4096);
        check("post_rst_valid", dac_valid, 1);
        check("post_rst_sat", sat_flag, 0);
        tick();
        check("post_rst_one_pulse", dac_valid, 0);
`else
        // 0 -> 512 in 64-code steps, with two more samples queued behind it.
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'h0000_1000;
        tick();
        check("slew_ready_k0", s_if.s_ready, 1);
        tick();
        check("slew_ready_k1", s_if.s_ready, 1);
        tick();
        s_if.s_valid = 1'b0;
        check("slew_step1", dac_data, MAX_STEP);
        check("slew_valid1", dac_valid, 1);
        check("slew_ready_full", s_if.s_ready, 0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("slew_step", dac_data, MAX_STEP * i);
            check("slew_valid", dac_valid, 1);
            check("slew_ready", s_if.s_ready, (i == 8) ? 1 : 0);
        end
        tick();
        check("held_b_dac", dac_data, 512);
        check("held_b_valid", dac_valid, 1);
        tick();
        check("held_c_dac", dac_data, 512);
        check("held_c_valid", dac_valid, 1);
        tick();
        check("slew_done_valid", dac_valid, 0);

        // Reset in the middle of a 512 -> -512 slew.
        send(32'hFFFF_F000);
        tick();
        tick();
        check("abort_step1", dac_data, 512 - MAX_STEP);
        tick();
        check("abort_step2", dac_data, 512 - 2 * MAX_STEP);
        adc_rst = 1'b1;
        #1;
        check("abort_ready_low", s_if.s_ready, 0);
        tick();
        check("abort_dac", dac_data, 0);
        check("abort_valid", dac_valid, 0);
        adc_rst = 1'b0;
        #1;
        check("abort_ready_high", s_if.s_ready, 1);
        tick();
        tick();
        check("abort_no_resume", dac_valid, 0);
        send(32'h0000_0200);
        tick();
        tick();
        check("post_abort_dac", dac_data, 64);
        check("post_abort_valid", dac_valid, 1);
        tick();
        check("post_abort_one_pulse", dac_valid, 0);
`endif

        // ------------------------------------------------ randomized stream
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        model_dac = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (dac_valid) score();
            if ($urandom_range(0, 7) == 0) begin
                smp = $urandom();
            end else begin
                code = int'($urandom_range(0, 2400)) - 1200;
                smp  = 32'(code * 8 + int'($urandom_range(0, 7)));
            end
            s_if.s_data  = smp;
            s_if.s_valid = ($urandom_range(0, 3) != 0);
            @(negedge adc_clk);
            took = s_if.s_valid && s_if.s_ready;
            tick();
            if (took) expect_sample(smp);
        end
        s_if.s_valid = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (dac_valid) score();
            if (exp_q.size() == 0) break;
            tick();
        end
        check("rand_drain_empty", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rand_no_extra", dac_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
